// File: rtl/complete_arbiter_pkg.sv
// rtl/complete_arbiter_pkg.sv - shared types and constants for the complete/writeback stage
package complete_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int TAG_W     = 5;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // One result as produced by an execute channel and held in its FIFO
  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [REG_IDX_W-1:0] dest_idx;
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      npc;
    logic                 take_branch;
  } fu_result_t;

  // One broadcast lane on the common data bus
  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [REG_IDX_W-1:0] dest_idx;
    logic [XLEN-1:0]      value;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      npc;
    logic                 take_branch;
  } cdb_lane_t;

  // Taken branches/jumps write the link address (npc) instead of the ALU result
  function automatic logic [XLEN-1:0] wb_value(input fu_result_t r);
    return r.take_branch ? r.npc : r.result;
  endfunction

endpackage

// File: rtl/complete_arbiter_fifo.sv
// rtl/complete_arbiter_fifo.sv - per-channel result FIFO with push/pop/flush
module complete_fifo
  import complete_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status comes from the registered count only: a full FIFO refuses pushes even on a pop cycle
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO and overrides push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents are don't-care while the slot is not counted
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/complete_arbiter.sv
// rtl/complete_arbiter.sv - round-robin multi-lane complete/writeback stage driving the CDB
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU     = 4,
  parameter int CDB_WIDTH  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    ex_valid,
  output logic [NUM_FU-1:0]                    ex_ready,
  input  logic [NUM_FU-1:0][TAG_W-1:0]         ex_tag,
  input  logic [NUM_FU-1:0][REG_IDX_W-1:0]     ex_dest_idx,
  input  logic [NUM_FU-1:0][XLEN-1:0]          ex_result,
  input  logic [NUM_FU-1:0][XLEN-1:0]          ex_pc,
  input  logic [NUM_FU-1:0][XLEN-1:0]          ex_npc,
  input  logic [NUM_FU-1:0]                    ex_take_branch,
  output logic [CDB_WIDTH-1:0]                 cdb_valid,
  output logic [CDB_WIDTH-1:0][TAG_W-1:0]      cdb_tag,
  output logic [CDB_WIDTH-1:0][REG_IDX_W-1:0]  cdb_dest_idx,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]       cdb_value,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]       cdb_pc,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]       cdb_npc,
  output logic [CDB_WIDTH-1:0]                 cdb_take_branch,
  output logic [CDB_WIDTH-1:0]                 wb_regfile_en,
  output logic [CDB_WIDTH-1:0][REG_IDX_W-1:0]  wb_regfile_idx,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]       wb_regfile_data
);

  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  if (CDB_WIDTH < 1 || CDB_WIDTH > NUM_FU) begin : g_cfg_check
    $error("complete_arbiter: CDB_WIDTH must be within 1..NUM_FU");
  end

  fu_result_t                         fifo_in   [NUM_FU];
  fu_result_t                         fifo_head [NUM_FU];
  logic [NUM_FU-1:0]                  fifo_full;
  logic [NUM_FU-1:0]                  fifo_empty;
  logic [NUM_FU-1:0]                  pop;
  logic [CDB_WIDTH-1:0]               grant_vld;
  logic [CDB_WIDTH-1:0][RR_W-1:0]     grant_ch;
  logic [RR_W-1:0]                    rr_ptr;
  logic [RR_W-1:0]                    rr_next;
  cdb_lane_t [CDB_WIDTH-1:0]          lane_d;
  cdb_lane_t [CDB_WIDTH-1:0]          lane_q;
  logic [CDB_WIDTH-1:0]               wb_en_d;
  logic [CDB_WIDTH-1:0]               wb_en_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_chan
    assign fifo_in[i] = '{
      tag:         ex_tag[i],
      dest_idx:    ex_dest_idx[i],
      result:      ex_result[i],
      pc:          ex_pc[i],
      npc:         ex_npc[i],
      take_branch: ex_take_branch[i]
    };
    assign ex_ready[i] = !fifo_full[i];

    complete_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(fu_result_t))
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (ex_valid[i]),
      .push_data (fifo_in[i]),
      .pop       (pop[i]),
      .pop_data  (fifo_head[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );
  end

  // Scan channels from rr_ptr and hand the first CDB_WIDTH non-empty ones to lanes 0,1,...
  always_comb begin
    int n;
    int ch;
    pop       = '0;
    grant_vld = '0;
    grant_ch  = '0;
    rr_next   = rr_ptr;
    n         = 0;
    ch        = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      ch = (int'(rr_ptr) + j) % NUM_FU;
      if (!fifo_empty[ch] && n < CDB_WIDTH) begin
        pop[ch]      = 1'b1;
        grant_vld[n] = 1'b1;
        grant_ch[n]  = RR_W'(ch);
        rr_next      = RR_W'((ch + 1) % NUM_FU);
        n            = n + 1;
      end
    end
  end

  // Build lane contents and drop regfile writes shadowed by a higher lane with the same dest
  always_comb begin
    fu_result_t r;
    r       = '0;
    lane_d  = '0;
    wb_en_d = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      r = fifo_head[grant_ch[k]];
      if (grant_vld[k]) begin
        lane_d[k].valid       = 1'b1;
        lane_d[k].tag         = r.tag;
        lane_d[k].dest_idx    = r.dest_idx;
        lane_d[k].value       = wb_value(r);
        lane_d[k].pc          = r.pc;
        lane_d[k].npc         = r.npc;
        lane_d[k].take_branch = r.take_branch;
      end
    end
    for (int k = 0; k < CDB_WIDTH; k++) begin
      wb_en_d[k] = lane_d[k].valid && (lane_d[k].dest_idx != ZERO_REG);
      for (int m = k + 1; m < CDB_WIDTH; m++) begin
        if (lane_d[m].valid && lane_d[m].dest_idx == lane_d[k].dest_idx) wb_en_d[k] = 1'b0;
      end
    end
  end

  // Registered CDB/writeback lanes; a flush blanks the lanes of the following cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q  <= '0;
      wb_en_q <= '0;
    end else if (flush) begin
      lane_q  <= '0;
      wb_en_q <= '0;
    end else begin
      lane_q  <= lane_d;
      wb_en_q <= wb_en_d;
    end
  end

  // Round-robin pointer moves past the last granted channel; flush leaves it alone
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (!flush) begin
      rr_ptr <= rr_next;
    end
  end

  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_lane_out
    assign cdb_valid[k]       = lane_q[k].valid;
    assign cdb_tag[k]         = lane_q[k].tag;
    assign cdb_dest_idx[k]    = lane_q[k].dest_idx;
    assign cdb_value[k]       = lane_q[k].value;
    assign cdb_pc[k]          = lane_q[k].pc;
    assign cdb_npc[k]         = lane_q[k].npc;
    assign cdb_take_branch[k] = lane_q[k].take_branch;
    assign wb_regfile_en[k]   = wb_en_q[k];
    assign wb_regfile_idx[k]  = lane_q[k].dest_idx;
    assign wb_regfile_data[k] = lane_q[k].value;
  end

endmodule
